// File: rtl/lightpong_pkg.sv
// Shared lightpong constants and types: clk_div divide settings and div_clk_monitor sizing/state encoding.
// Compile-time only; no latency, no flow control.
package lightpong_pkg;

  localparam int CLK_DIV_W     = 16;
  localparam int CLK_DIV_RATIO = 50_000;

  localparam int                     MON_CNT_W   = 24;
  localparam logic [MON_CNT_W-1:0]   MON_TIMEOUT = 24'd10_000_000;

  // Kept as plain vectors so older netlists and probes see stable encodings.
  typedef logic [1:0] mon_state_t;
  localparam mon_state_t MON_IDLE    = 2'd0;
  localparam mon_state_t MON_ARMED   = 2'd1;
  localparam mon_state_t MON_STALLED = 2'd2;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus delay flop; registered rise pulse 2 clk edges after din is first sampled high.
// No backpressure: one rise per 0->1 transition, none until the pipeline holds real post-reset samples.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic       sync1;
  logic       sync2;
  logic       sync3;
  logic [2:0] fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      fill  <= 3'b000;
      rise  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      sync3 <= sync2;
      fill  <= {fill[1:0], 1'b1};
      // fill[2] masks the reset-zero in sync3 so a din held high across reset is not a rise.
      rise  <= fill[2] & sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/div_clk_monitor.sv
// Measures div_clk period in clk cycles and flags a stopped div_clk; edge_tick 3 clk edges after first high sample.
// No backpressure: period/period_valid and stalled update in step with edge_tick.
module div_clk_monitor
  import lightpong_pkg::*;
#(
  parameter int               CNT_W   = MON_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(MON_TIMEOUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_clk,
  output logic             edge_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             stalled
);

  logic             rise;
  logic [CNT_W-1:0] cnt;
  mon_state_t       state;

  edge_sync u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (div_clk),
    .rise (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      state        <= MON_IDLE;
      edge_tick    <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      edge_tick    <= rise;
      period_valid <= 1'b0;
      if (rise) begin
        // An edge always beats a coincident timeout.
        cnt     <= CNT_W'(1);
        state   <= MON_ARMED;
        stalled <= 1'b0;
        if (state == MON_ARMED) begin
          period       <= cnt;
          period_valid <= 1'b1;
        end
      end else begin
        if (cnt != TIMEOUT) begin
          cnt <= cnt + CNT_W'(1);
        end
        if (state == MON_STALLED) begin
          stalled <= 1'b1;
        end else if (cnt == TIMEOUT) begin
          state <= MON_STALLED;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Self-checking bench for div_clk_monitor with TIMEOUT=100 and a 4 ns clk.
module tb_div_clk_monitor;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_clk = 1'b0;
  logic        edge_tick;
  logic [23:0] period;
  logic        period_valid;
  logic        stalled;

  always #2 clk = ~clk;

  div_clk_monitor #(.CNT_W(24), .TIMEOUT(24'd100)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_clk      (div_clk),
    .edge_tick    (edge_tick),
    .period       (period),
    .period_valid (period_valid),
    .stalled      (stalled)
  );

  int checks = 0;
  int errors = 0;
  int tick_seen = 0;
  int pv_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: works on absolute cycle numbers. A div_clk rise sampled at
  // edge j-3 (low at j-4, both after reset) shows as edge_tick after edge j.
  // Period is the distance between ticks; more than TO+1 cycles without a tick
  // means stalled, and a tick after a stall or reset starts a fresh reference.
  int          mj = 0;
  int          mr = -100;
  int          ml = 0;
  bit          mref = 1'b0;
  bit          sh [5];
  logic        e_tick = 1'b0;
  logic        e_pv = 1'b0;
  logic        e_st = 1'b0;
  logic [23:0] e_per = '0;

  initial forever begin
    @(negedge clk);
    mj++;
    for (int k = 4; k > 0; k--) sh[k] = sh[k-1];
    sh[0] = div_clk;
    if (rst) begin
      mr = mj; ml = mj + 1; mref = 1'b0;
      e_tick = 1'b0; e_pv = 1'b0; e_st = 1'b0; e_per = '0;
    end else begin
      e_tick = (mj - 4 > mr) && sh[3] && !sh[4];
      e_pv = 1'b0;
      if (e_tick) begin
        if (mref && (mj - ml <= TO)) begin
          e_pv  = 1'b1;
          e_per = 24'(mj - ml);
        end
        ml = mj; mref = 1'b1; e_st = 1'b0;
      end else begin
        e_st = (mj - ml >= TO + 1);
      end
    end
    check("model edge_tick", 32'(edge_tick), 32'(e_tick));
    check("model period_valid", 32'(period_valid), 32'(e_pv));
    check("model period", 32'(period), 32'(e_per));
    check("model stalled", 32'(stalled), 32'(e_st));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      tick_seen += int'(edge_tick === 1'b1);
      pv_seen   += int'(period_valid === 1'b1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  int          nt;
  logic        t_pv  [4];
  logic [23:0] t_per [4];
  logic        t_st  [4];

  // Drive div_clk high for hi of every per cycles; capture outputs at up to 4 ticks.
  task automatic watch(input int ncyc, input int hi, input int per);
    nt = 0;
    for (int k = 0; k < ncyc; k++) begin
      div_clk = (k % per) < hi;
      step(1);
      if (edge_tick === 1'b1) begin
        if (nt < 4) begin
          t_pv[nt] = period_valid; t_per[nt] = period; t_st[nt] = stalled;
        end
        nt++;
      end
    end
  endtask

  typedef struct {
    int hi;
    int lo;
    int n;
    int exp_per;
    int exp_nv;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int last_t;
    int st_t;
    tbl[0] = '{8, 8, 4, 16, 3};
    tbl[1] = '{1, 3, 5, 4, 4};
    tbl[2] = '{1, 1, 6, 2, 5};
    tbl[3] = '{3, 10, 4, 13, 3};
    tbl[4] = '{50, 50, 3, 100, 2};
    tbl[5] = '{70, 30, 3, 100, 2};
    tbl[6] = '{60, 41, 3, 0, 0};

    rst = 1'b1; div_clk = 1'b0;
    step(2);
    check("reset edge_tick", 32'(edge_tick), 0);
    check("reset period", 32'(period), 0);
    check("reset period_valid", 32'(period_valid), 0);
    check("reset stalled", 32'(stalled), 0);
    rst = 1'b0;
    step(8);

    // Single-cycle high pulse: edge_tick exactly 3 edges after the sampling edge.
    div_clk = 1'b1; step(1);
    check("lat edge+0", 32'(edge_tick), 0);
    div_clk = 1'b0; step(1);
    check("lat edge+1", 32'(edge_tick), 0);
    step(1);
    check("lat edge+2", 32'(edge_tick), 0);
    step(1);
    check("lat edge+3", 32'(edge_tick), 1);
    check("lat first pv", 32'(period_valid), 0);
    step(1);
    check("lat edge+4", 32'(edge_tick), 0);

    foreach (tbl[i]) begin
      do_reset();
      step(10);
      pv_seen = 0; tick_seen = 0;
      repeat (tbl[i].n) begin
        div_clk = 1'b1; step(tbl[i].hi);
        div_clk = 1'b0; step(tbl[i].lo);
      end
      step(8);
      check($sformatf("tbl[%0d] ticks", i), tick_seen, tbl[i].n);
      check($sformatf("tbl[%0d] valid count", i), pv_seen, tbl[i].exp_nv);
      check($sformatf("tbl[%0d] period", i), 32'(period), tbl[i].exp_per);
    end

    // Three edges, then div_clk held low for 150 cycles.
    do_reset();
    step(10);
    last_t = -1000; st_t = -1;
    for (int k = 0; k < 198; k++) begin
      div_clk = (k < 48) && ((k % 16) < 8);
      step(1);
      if (edge_tick === 1'b1) last_t = k;
      if (stalled === 1'b1 && st_t < 0) st_t = k;
    end
    check("stall delay after tick", st_t - last_t, 101);
    check("stall period held", 32'(period), 16);
    check("stall level", 32'(stalled), 1);

    watch(40, 8, 16);
    check("resume ticks", 32'(nt >= 2), 1);
    check("resume stalled clears", 32'(t_st[0]), 0);
    check("resume first pv", 32'(t_pv[0]), 0);
    check("resume second pv", 32'(t_pv[1]), 1);
    check("resume second period", 32'(t_per[1]), 16);

    // Reset 5 cycles after an edge.
    do_reset();
    step(10);
    div_clk = 1'b1; step(8);
    div_clk = 1'b0; step(1);
    rst = 1'b1; step(1); rst = 1'b0;
    check("midrst edge_tick", 32'(edge_tick), 0);
    check("midrst period", 32'(period), 0);
    check("midrst period_valid", 32'(period_valid), 0);
    check("midrst stalled", 32'(stalled), 0);
    step(6);
    watch(40, 8, 16);
    check("midrst ticks", 32'(nt >= 2), 1);
    check("midrst first pv", 32'(t_pv[0]), 0);
    check("midrst second pv", 32'(t_pv[1]), 1);
    check("midrst second period", 32'(t_per[1]), 16);

    // div_clk high across reset release.
    rst = 1'b1; div_clk = 1'b1;
    step(3);
    rst = 1'b0;
    tick_seen = 0;
    step(20);
    check("held high no tick", tick_seen, 0);
    div_clk = 1'b0; step(3);
    watch(10, 5, 100);
    check("fresh rise ticks", nt, 1);

    // Edge in the cycle cnt reaches TIMEOUT.
    do_reset();
    step(10);
    watch(250, 50, 100);
    check("boundary ticks", nt, 3);
    check("boundary pv", 32'(t_pv[1]), 1);
    check("boundary period", 32'(t_per[1]), 100);
    check("boundary stalled", 32'(t_st[1]), 0);

    // Random traffic against the model, with occasional resets and stalls.
    do_reset();
    step(10);
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0: begin
          rst = 1'b1; step($urandom_range(1, 3)); rst = 1'b0;
        end
        1: begin
          div_clk = 1'b0; step($urandom_range(95, 130));
        end
        default: begin
          div_clk = 1'b1; step($urandom_range(1, 30));
          div_clk = 1'b0; step($urandom_range(1, 75));
        end
      endcase
    end
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_clk_monitor.md
DIV_CLK_MONITOR -- requirements
Module: div_clk_monitor

Interface
REQ-001 Parameter CNT_W, default 24: width of the period counter and the period output.
REQ-002 Parameter TIMEOUT, default 24'd10_000_000: clk cycles without a div_clk rising edge before the stall flag is raised. Legal range is 2 to 2^CNT_W-1.
REQ-003 clk  input  1  sole clock; all logic updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 div_clk  input  1  divided clock under observation; treated as asynchronous to clk.
REQ-006 edge_tick  output  1  one-cycle pulse per detected div_clk rising edge.
REQ-007 period  output  CNT_W  last measured div_clk period, in clk cycles.
REQ-008 period_valid  output  1  one-cycle pulse when period updates.
REQ-009 stalled  output  1  level, high while div_clk is considered stopped.

Function
REQ-010 div_clk SHALL pass through a 2-flop synchronizer, then a third delay flop; rising edge = sync2 & ~sync3.
REQ-011 edge_tick SHALL be registered and rise exactly 3 clk edges after the first clk edge that samples div_clk high; it is high for exactly one cycle.
REQ-012 Period counter cnt SHALL load 1 in the cycle edge_tick is asserted, increment by 1 otherwise, and saturate at TIMEOUT (no wrap).
REQ-013 FSM states SHALL be IDLE, ARMED and STALLED.
- IDLE: entered at reset.
- First edge: IDLE→ARMED, with no period_valid.
- Subsequent edges in ARMED: period <= cnt, period_valid=1 for one cycle, same cycle as edge_tick.
REQ-014 Example: edge_tick pulses in cycles 10 and 14 SHALL yield period=4 and period_valid in cycle 14.
REQ-015 In ARMED or IDLE, if cnt reaches TIMEOUT with no edge, the FSM SHALL go to STALLED and set stalled=1 on the next cycle; period holds its value.
REQ-016 In STALLED, the next edge SHALL go to ARMED and clear stalled in the same cycle as edge_tick. No period_valid is issued, because the stalled interval is not a valid period.
REQ-017 If an edge and the timeout condition coincide in the same cycle, the edge SHALL win: no stall, and normal period handling applies.
REQ-018 period_valid SHALL never assert in IDLE or STALLED, nor on the first edge after either.
REQ-019 A div_clk level held high or low indefinitely SHALL produce no edge_tick; only 0→1 transitions count.

Reset
REQ-020 Synchronous rst SHALL set:
- synchronizer flops = 0
- cnt = 0
- FSM = IDLE
- edge_tick = 0, period = 0, period_valid = 0, stalled = 0
REQ-021 rst asserted mid-measurement SHALL discard the partial count. The first post-reset edge produces no period_valid.
REQ-022 A div_clk high at reset release SHALL NOT produce an edge_tick until a fresh low→high transition.

Structure
REQ-023 CNT_W and the default TIMEOUT SHALL live in the shared lightpong_pkg package, alongside the clk_div divide constants.
REQ-024 The FSM state encoding SHALL be a typedef in lightpong_pkg.
REQ-025 The synchronizer and edge detect SHALL be one sub-module, edge_sync (ports clk, rst, din, rise).
REQ-026 div_clk_monitor SHALL instantiate edge_sync once and implement the counter and FSM itself.

Verification (bench uses TIMEOUT=100, clk period 4 ns)
REQ-027 rst high for 10 ns, then div_clk toggling every 8 clk cycles:
- no period_valid on the first edge;
- every later edge gives period=16 with period_valid;
- stalled stays 0.
REQ-028 div_clk rises in a single clk cycle: edge_tick is high exactly 3 clk edges later, for 1 cycle.
REQ-029 div_clk held low for 150 cycles after 3 edges:
- stalled rises 101 cycles after the last edge_tick;
- period holds 16.
REQ-030 Next edge after the stall: stalled falls with edge_tick and there is no period_valid; the following edge 16 cycles later gives period=16 with period_valid.
REQ-031 rst pulsed 5 cycles after an edge, with div_clk period 16: all outputs are 0; the first post-reset edge gives no period_valid; the second gives period=16.
REQ-032 An edge arriving in the exact cycle cnt reaches 100 gives period=100, period_valid=1 and stalled=0.
